// File: rtl/hsi_element_streamer_if.sv
// rtl/hsi_element_streamer_if.sv - library read bus and element stream between streamer, memory and MSE block
interface hsi_element_streamer_if #(
    parameter int WORD_WIDTH = 32,
    parameter int LIB_ADDR   = 8,
    parameter int WPV_ADDR   = 6
);
    logic                         lib_rd_en;
    logic [LIB_ADDR+WPV_ADDR-1:0] lib_rd_addr;
    logic [WORD_WIDTH-1:0]        lib_rd_data;
    logic                         element_valid;
    logic                         element_start;
    logic                         element_last;
    logic [LIB_ADDR-1:0]          vctr_ref;
    logic [WORD_WIDTH-1:0]        element_a;
    logic [WORD_WIDTH-1:0]        element_b;

    modport master (
        output lib_rd_en, lib_rd_addr,
        input  lib_rd_data,
        output element_valid, element_start, element_last, vctr_ref, element_a, element_b
    );

    modport slave (
        input  lib_rd_en, lib_rd_addr,
        output lib_rd_data,
        input  element_valid, element_start, element_last, vctr_ref, element_a, element_b
    );
endinterface

// File: rtl/hsi_element_streamer.sv
// rtl/hsi_element_streamer.sv - pairs a buffered pixel vector with each library vector for the MSE pipeline
module hsi_element_streamer #(
    parameter  int WORD_WIDTH       = 32,
    parameter  int DATA_WIDTH       = 16,
    parameter  int HSI_BANDS        = 128,
    parameter  int HSI_LIBRARY_SIZE = 256,
    localparam int WPV              = HSI_BANDS * DATA_WIDTH / WORD_WIDTH,
    localparam int WPV_ADDR         = $clog2(WPV),
    localparam int LIB_ADDR         = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_wr_en,
    input  logic [WPV_ADDR-1:0]   pxl_wr_addr,
    input  logic [WORD_WIDTH-1:0] pxl_wr_data,
    input  logic                  start,
    input  logic [LIB_ADDR:0]     lib_size,
    output logic                  busy,
    output logic                  done,
    hsi_element_streamer_if.master bus
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [LIB_ADDR:0]     eff_size, eff_clamped;
    logic [LIB_ADDR-1:0]   v;
    logic [WPV_ADDR-1:0]   w;
    logic                  last_rd, rd_en;
    logic [WORD_WIDTH-1:0] pixel_buf [WPV];
    logic                  valid_q, start_q, last_q;
    logic [LIB_ADDR-1:0]   vref_q;
    logic [WORD_WIDTH-1:0] elem_a_q;

    assign eff_clamped = (lib_size > (LIB_ADDR+1)'(HSI_LIBRARY_SIZE))
                         ? (LIB_ADDR+1)'(HSI_LIBRARY_SIZE) : lib_size;
    assign last_rd     = ({1'b0, v} == eff_size - (LIB_ADDR+1)'(1))
                         && (w == WPV_ADDR'(WPV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An empty sweep passes through DRAIN so done lands two cycles after start.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (eff_clamped == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                rd_en = 1'b1;
                if (last_rd) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff_size <= '0;
            v        <= '0;
            w        <= '0;
        end else if (state == IDLE && start) begin
            eff_size <= eff_clamped;
            v        <= '0;
            w        <= '0;
        end else if (state == STREAM && !last_rd) begin
            if (w == WPV_ADDR'(WPV - 1)) begin
                w <= '0;
                v <= v + LIB_ADDR'(1);
            end else begin
                w <= w + WPV_ADDR'(1);
            end
        end
    end

    // Writes only land while idle, so the vector cannot change under a sweep.
    always_ff @(posedge clk) begin
        if (pxl_wr_en && state == IDLE) pixel_buf[pxl_wr_addr] <= pxl_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            vref_q   <= '0;
            elem_a_q <= '0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                start_q  <= (w == '0);
                last_q   <= (w == WPV_ADDR'(WPV - 1));
                vref_q   <= v;
                elem_a_q <= pixel_buf[w];
            end
        end
    end

    assign bus.lib_rd_en     = rd_en;
    assign bus.lib_rd_addr   = {v, w};
    assign bus.element_valid = valid_q;
    assign bus.element_start = start_q;
    assign bus.element_last  = last_q;
    assign bus.vctr_ref      = vref_q;
    assign bus.element_a     = elem_a_q;
    assign bus.element_b     = valid_q ? bus.lib_rd_data : '0;
endmodule

// File: tb/tb_hsi_element_streamer.sv
// tb/tb_hsi_element_streamer.sv - directed/randomized bench for hsi_element_streamer
module tb_hsi_element_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_wr_en = 1'b0;
    logic [5:0]  pxl_wr_addr = '0;
    logic [31:0] pxl_wr_data = '0;
    logic        start = 1'b0;
    logic [8:0]  lib_size = '0;
    logic        busy, done;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] pix_model [64];
    int          lib_mode = 0;
    logic [31:0] salt = '0;

    hsi_element_streamer_if bus ();

    hsi_element_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .pxl_wr_en   (pxl_wr_en),
        .pxl_wr_addr (pxl_wr_addr),
        .pxl_wr_data (pxl_wr_data),
        .start       (start),
        .lib_size    (lib_size),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lib_word(input logic [13:0] addr);
        case (lib_mode)
            0:       return 32'(addr) + 32'h100;
            1:       return (32'(addr) * 32'h9E3779B1) ^ salt;
            default: return (addr[13:6] == 8'd3) ? pix_model[addr[5:0]] : ((32'(addr) * 32'h9E3779B1) ^ salt) | 32'h1;
        endcase
    endfunction

    // Library memory: one-cycle read latency.
    always @(posedge clk) bus.lib_rd_data <= bus.lib_rd_en ? lib_word(bus.lib_rd_addr) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_rd_en"}, 64'(bus.lib_rd_en), 0);
        chk({tag, "_addr"},  64'(bus.lib_rd_addr), 0);
        chk({tag, "_valid"}, 64'(bus.element_valid), 0);
        chk({tag, "_start"}, 64'(bus.element_start), 0);
        chk({tag, "_last"},  64'(bus.element_last), 0);
        chk({tag, "_vref"},  64'(bus.vctr_ref), 0);
        chk({tag, "_a"},     64'(bus.element_a), 0);
        chk({tag, "_b"},     64'(bus.element_b), 0);
    endtask

    task automatic write_pix(input int idx, input logic [31:0] data);
        pxl_wr_en = 1'b1; pxl_wr_addr = 6'(idx); pxl_wr_data = data;
        @(posedge clk); #1;
        pxl_wr_en = 1'b0;
        pix_model[idx] = data;
    endtask

    // Called 1 time unit after a rising edge; that cycle is cycle 0 (start high).
    task automatic run_sweep(input int lsz, input int perturb_cycle, input int abort_cycle);
        int     eff, n, e, v, w, d0, d1;
        longint acc;
        eff = (lsz > 256) ? 256 : lsz;
        n   = eff * 64;
        acc = 0;
        start = 1'b1; lib_size = 9'(lsz);
        @(posedge clk); #1;
        for (int c = 1; c <= n + 3; c++) begin
            if (c == perturb_cycle) begin
                start = 1'b1; pxl_wr_en = 1'b1; pxl_wr_addr = 6'd5; pxl_wr_data = 32'hDEADBEEF;
            end else begin
                start = 1'b0; pxl_wr_en = 1'b0;
            end
            @(negedge clk);
            chk("busy",  64'(busy), 64'(c <= n + 2));
            chk("done",  64'(done), 64'(c == n + 2));
            chk("rd_en", 64'(bus.lib_rd_en), 64'(c <= n));
            if (c <= n) chk("rd_addr", 64'(bus.lib_rd_addr), 64'(c - 1));
            chk("valid", 64'(bus.element_valid), 64'(c >= 2 && c <= n + 1));
            if (c >= 2 && c <= n + 1) begin
                e = c - 2; v = e / 64; w = e % 64;
                chk("elem_a",     64'(bus.element_a), 64'(pix_model[w]));
                chk("elem_b",     64'(bus.element_b), 64'(lib_word(14'(e))));
                chk("elem_start", 64'(bus.element_start), 64'(w == 0));
                chk("elem_last",  64'(bus.element_last), 64'(w == 63));
                chk("vctr_ref",   64'(bus.vctr_ref), 64'(v));
                if (lib_mode == 2) begin
                    if (w == 0) acc = 0;
                    d0 = int'(bus.element_a[15:0])  - int'(bus.element_b[15:0]);
                    d1 = int'(bus.element_a[31:16]) - int'(bus.element_b[31:16]);
                    acc += longint'(d0 * d0) + longint'(d1 * d1);
                    if (w == 63) chk("mse_zero", 64'(acc == 0), 64'(v == 3));
                end
            end
            if (c == abort_cycle) begin
                rst = 1'b1; #1;
                chk_all_zero("abort");
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Incrementing pixel words against addr+0x100 library, two vectors.
        for (int i = 0; i < 64; i++) write_pix(i, 32'(i));
        lib_mode = 0;
        run_sweep(2, 0, 0);

        // Empty library.
        run_sweep(0, 0, 0);

        // Random data; start and pixel write during sweep must be ignored.
        for (int i = 0; i < 64; i++) write_pix(i, $urandom);
        lib_mode = 1; salt = $urandom;
        run_sweep(3, 10, 0);
        run_sweep(1, 0, 0);

        // Pixel write in the start cycle lands; oversize library clamps to 256.
        pxl_wr_en = 1'b1; pxl_wr_addr = 6'd0; pxl_wr_data = $urandom;
        pix_model[0] = pxl_wr_data;
        run_sweep(300, 0, 0);

        // Reset at element #40 of vector 1, then a clean restart.
        salt = $urandom;
        run_sweep(2, 0, 106);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_done", 64'(done), 0);
            chk("rst_busy", 64'(busy), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_sweep(1, 0, 0);

        // Library vector 3 equals the pixel vector.
        lib_mode = 2; salt = $urandom;
        run_sweep(5, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
